// File: rtl/transmit.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// A holding register in front of the frame shift register lets frames run back to back.
module transmit #(
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       transmit_baud,
  input  logic       transmit_write_en,
  input  logic [7:0] transmit_write_line,
  output logic       txd,
  output logic       tbr,
  output logic       tx_busy
);

  localparam int         FRAME_LEN = 10 + PARITY_EN + (STOP_BITS - 1);
  localparam logic [3:0] LAST_BIT  = 4'(FRAME_LEN - 1);
  localparam logic       PAR_ON    = (PARITY_EN != 0);
  localparam logic       ODD_BIT   = (PARITY_ODD != 0);

  typedef enum logic {IDLE, SEND} state_e;

  state_e      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [10:0] shift_q, shift_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic        txd_q, txd_d;
  logic        load;
  logic        parity_bit;
  logic [10:0] frame_tail;

  // Bits that follow the start bit; slots past the frame end are padded with 1s.
  assign parity_bit = (^hold_q) ^ ODD_BIT;
  assign frame_tail = {2'b11, (PAR_ON ? parity_bit : 1'b1), hold_q};

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    txd_d       = txd_q;
    load        = 1'b0;

    case (state_q)
      IDLE: begin
        if (transmit_baud && hold_full_q) begin
          load = 1'b1;
        end
      end
      SEND: begin
        if (transmit_baud) begin
          if (bit_cnt_q == LAST_BIT) begin
            if (hold_full_q) begin
              load = 1'b1;
            end else begin
              txd_d   = 1'b1;
              state_d = IDLE;
            end
          end else begin
            txd_d     = shift_q[0];
            shift_d   = {1'b1, shift_q[10:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A load needs a full holding register and a write needs an empty one, so they never collide.
    if (load) begin
      shift_d     = frame_tail;
      txd_d       = 1'b0;
      bit_cnt_d   = 4'd0;
      hold_full_d = 1'b0;
      state_d     = SEND;
    end else if (transmit_write_en && !hold_full_q) begin
      hold_d      = transmit_write_line;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 4'd0;
      shift_q     <= '1;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      txd_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      txd_q       <= txd_d;
    end
  end

  assign txd     = txd_q;
  assign tbr     = ~hold_full_q;
  assign tx_busy = (state_q == SEND);

endmodule

// File: tb/tb_transmit.sv
// Directed bench for the UART transmitter; four instances cover default, even/odd parity and two stop bits.
module tb_transmit;

  logic       clk = 1'b0;
  logic       rst, baud, wen;
  logic [7:0] wdata;
  logic       txd_def, tbr_def, busy_def;
  logic       txd_pe, tbr_pe, busy_pe;
  logic       txd_po, tbr_po, busy_po;
  logic       txd_s2, tbr_s2, busy_s2;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  transmit dut_def (
    .clk(clk), .rst(rst), .transmit_baud(baud), .transmit_write_en(wen),
    .transmit_write_line(wdata), .txd(txd_def), .tbr(tbr_def), .tx_busy(busy_def)
  );

  transmit #(.PARITY_EN(1), .PARITY_ODD(0)) dut_pe (
    .clk(clk), .rst(rst), .transmit_baud(baud), .transmit_write_en(wen),
    .transmit_write_line(wdata), .txd(txd_pe), .tbr(tbr_pe), .tx_busy(busy_pe)
  );

  transmit #(.PARITY_EN(1), .PARITY_ODD(1)) dut_po (
    .clk(clk), .rst(rst), .transmit_baud(baud), .transmit_write_en(wen),
    .transmit_write_line(wdata), .txd(txd_po), .tbr(tbr_po), .tx_busy(busy_po)
  );

  transmit #(.STOP_BITS(2)) dut_s2 (
    .clk(clk), .rst(rst), .transmit_baud(baud), .transmit_write_en(wen),
    .transmit_write_line(wdata), .txd(txd_s2), .tbr(tbr_s2), .tx_busy(busy_s2)
  );

  task automatic clk_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns on the negedge right after the strobed posedge.
  task automatic strobe();
    baud = 1'b1;
    @(negedge clk);
    baud = 1'b0;
  endtask

  task automatic host_write(input logic [7:0] b);
    wen   = 1'b1;
    wdata = b;
    @(negedge clk);
    wen   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    baud = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    baud = 1'b0;
    checks++; if (txd_def !== 1'b1) begin errors++; $display("[TB] FAIL reset_txd got %b want 1", txd_def); end
    checks++; if (tbr_def !== 1'b1) begin errors++; $display("[TB] FAIL reset_tbr got %b want 1", tbr_def); end
    checks++; if (busy_def !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy_def); end
    checks++; if (tbr_s2 !== 1'b1) begin errors++; $display("[TB] FAIL reset_tbr_s2 got %b want 1", tbr_s2); end
  endtask

  task automatic test_single_frame();
    logic [9:0] exp;
    exp = {1'b1, 8'h55, 1'b0};
    do_reset();
    host_write(8'h55);
    checks++; if (tbr_def !== 1'b0) begin errors++; $display("[TB] FAIL single_tbr_after_write got %b want 0", tbr_def); end
    clk_cycles(5);
    checks++; if (txd_def !== 1'b1) begin errors++; $display("[TB] FAIL single_idle_txd got %b want 1", txd_def); end
    checks++; if (busy_def !== 1'b0) begin errors++; $display("[TB] FAIL single_idle_busy got %b want 0", busy_def); end
    for (int i = 0; i < 10; i++) begin
      strobe();
      checks++; if (txd_def !== exp[i]) begin errors++; $display("[TB] FAIL single_bit%0d got %b want %b", i, txd_def, exp[i]); end
      checks++; if (busy_def !== 1'b1) begin errors++; $display("[TB] FAIL single_busy%0d got %b want 1", i, busy_def); end
      if (i == 0) begin
        checks++; if (tbr_def !== 1'b1) begin errors++; $display("[TB] FAIL single_tbr_after_load got %b want 1", tbr_def); end
      end
      clk_cycles(15);
    end
    strobe();
    checks++; if (txd_def !== 1'b1) begin errors++; $display("[TB] FAIL single_end_txd got %b want 1", txd_def); end
    checks++; if (busy_def !== 1'b0) begin errors++; $display("[TB] FAIL single_end_busy got %b want 0", busy_def); end
    clk_cycles(15);
  endtask

  task automatic test_back_to_back();
    logic [19:0] exp;
    exp = {1'b1, 8'h0F, 1'b0, 1'b1, 8'hA3, 1'b0};
    do_reset();
    host_write(8'hA3);
    clk_cycles(3);
    for (int i = 0; i < 20; i++) begin
      strobe();
      checks++; if (txd_def !== exp[i]) begin errors++; $display("[TB] FAIL b2b_bit%0d got %b want %b", i, txd_def, exp[i]); end
      checks++; if (busy_def !== 1'b1) begin errors++; $display("[TB] FAIL b2b_busy%0d got %b want 1", i, busy_def); end
      if (i == 2) begin
        checks++; if (tbr_def !== 1'b1) begin errors++; $display("[TB] FAIL b2b_tbr_before got %b want 1", tbr_def); end
        host_write(8'h0F);
        checks++; if (tbr_def !== 1'b0) begin errors++; $display("[TB] FAIL b2b_tbr_after got %b want 0", tbr_def); end
        host_write(8'h77);
        clk_cycles(13);
      end else begin
        clk_cycles(15);
      end
    end
    for (int k = 0; k < 3; k++) begin
      strobe();
      checks++; if (txd_def !== 1'b1) begin errors++; $display("[TB] FAIL b2b_tail_txd%0d got %b want 1", k, txd_def); end
      checks++; if (busy_def !== 1'b0) begin errors++; $display("[TB] FAIL b2b_tail_busy%0d got %b want 0", k, busy_def); end
      clk_cycles(15);
    end
    checks++; if (tbr_def !== 1'b1) begin errors++; $display("[TB] FAIL b2b_tbr_end got %b want 1", tbr_def); end
  endtask

  task automatic test_parity();
    logic [10:0] exp_even, exp_odd;
    exp_even = {1'b1, 1'b1, 8'h07, 1'b0};
    exp_odd  = {1'b1, 1'b0, 8'h07, 1'b0};
    do_reset();
    host_write(8'h07);
    clk_cycles(2);
    for (int i = 0; i < 11; i++) begin
      strobe();
      checks++; if (txd_pe !== exp_even[i]) begin errors++; $display("[TB] FAIL par_even_bit%0d got %b want %b", i, txd_pe, exp_even[i]); end
      checks++; if (txd_po !== exp_odd[i]) begin errors++; $display("[TB] FAIL par_odd_bit%0d got %b want %b", i, txd_po, exp_odd[i]); end
      checks++; if (busy_pe !== 1'b1) begin errors++; $display("[TB] FAIL par_busy%0d got %b want 1", i, busy_pe); end
      clk_cycles(15);
    end
    strobe();
    checks++; if (busy_pe !== 1'b0) begin errors++; $display("[TB] FAIL par_even_end_busy got %b want 0", busy_pe); end
    checks++; if (busy_po !== 1'b0) begin errors++; $display("[TB] FAIL par_odd_end_busy got %b want 0", busy_po); end
    checks++; if (txd_pe !== 1'b1) begin errors++; $display("[TB] FAIL par_end_txd got %b want 1", txd_pe); end
    checks++; if (tbr_po !== 1'b1) begin errors++; $display("[TB] FAIL par_end_tbr got %b want 1", tbr_po); end
    clk_cycles(15);
  endtask

  task automatic test_stop2();
    logic [10:0] exp;
    exp = {1'b1, 1'b1, 8'hFF, 1'b0};
    do_reset();
    host_write(8'hFF);
    clk_cycles(2);
    for (int i = 0; i < 11; i++) begin
      strobe();
      checks++; if (txd_s2 !== exp[i]) begin errors++; $display("[TB] FAIL stop2_bit%0d got %b want %b", i, txd_s2, exp[i]); end
      checks++; if (busy_s2 !== 1'b1) begin errors++; $display("[TB] FAIL stop2_busy%0d got %b want 1", i, busy_s2); end
      clk_cycles(15);
    end
    strobe();
    checks++; if (busy_s2 !== 1'b0) begin errors++; $display("[TB] FAIL stop2_end_busy got %b want 0", busy_s2); end
    checks++; if (txd_s2 !== 1'b1) begin errors++; $display("[TB] FAIL stop2_end_txd got %b want 1", txd_s2); end
    clk_cycles(15);
  endtask

  task automatic test_reset_mid_frame();
    logic [9:0] exp;
    exp = {1'b1, 8'hC3, 1'b0};
    do_reset();
    host_write(8'hC3);
    clk_cycles(2);
    for (int i = 0; i < 6; i++) begin
      strobe();
      checks++; if (txd_def !== exp[i]) begin errors++; $display("[TB] FAIL midrst_bit%0d got %b want %b", i, txd_def, exp[i]); end
      clk_cycles(15);
    end
    host_write(8'h99);
    checks++; if (tbr_def !== 1'b0) begin errors++; $display("[TB] FAIL midrst_queued_tbr got %b want 0", tbr_def); end
    do_reset();
    checks++; if (txd_def !== 1'b1) begin errors++; $display("[TB] FAIL midrst_txd got %b want 1", txd_def); end
    checks++; if (tbr_def !== 1'b1) begin errors++; $display("[TB] FAIL midrst_tbr got %b want 1", tbr_def); end
    checks++; if (busy_def !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy got %b want 0", busy_def); end
    for (int i = 0; i < 12; i++) begin
      strobe();
      checks++; if (txd_def !== 1'b1) begin errors++; $display("[TB] FAIL midrst_after_txd%0d got %b want 1", i, txd_def); end
      checks++; if (busy_def !== 1'b0) begin errors++; $display("[TB] FAIL midrst_after_busy%0d got %b want 0", i, busy_def); end
      clk_cycles(15);
    end
  endtask

  task automatic test_baud_stuck();
    logic [9:0] exp;
    exp = {1'b1, 8'h81, 1'b0};
    do_reset();
    host_write(8'h81);
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      checks++; if (txd_def !== 1'b1) begin errors++; $display("[TB] FAIL stuck_txd_cycle%0d got %b want 1", c, txd_def); end
    end
    checks++; if (tbr_def !== 1'b0) begin errors++; $display("[TB] FAIL stuck_tbr got %b want 0", tbr_def); end
    for (int i = 0; i < 10; i++) begin
      strobe();
      checks++; if (txd_def !== exp[i]) begin errors++; $display("[TB] FAIL stuck_bit%0d got %b want %b", i, txd_def, exp[i]); end
      if (i == 0) begin
        checks++; if (busy_def !== 1'b1) begin errors++; $display("[TB] FAIL stuck_busy got %b want 1", busy_def); end
        checks++; if (tbr_def !== 1'b1) begin errors++; $display("[TB] FAIL stuck_tbr_load got %b want 1", tbr_def); end
      end
      clk_cycles(15);
    end
    strobe();
    checks++; if (busy_def !== 1'b0) begin errors++; $display("[TB] FAIL stuck_end_busy got %b want 0", busy_def); end
    clk_cycles(15);
  endtask

  // A write coinciding with a strobe must wait for the next strobe.
  task automatic test_latency();
    do_reset();
    wen   = 1'b1;
    wdata = 8'h5A;
    baud  = 1'b1;
    @(negedge clk);
    wen   = 1'b0;
    baud  = 1'b0;
    checks++; if (txd_def !== 1'b1) begin errors++; $display("[TB] FAIL lat_same_cycle_txd got %b want 1", txd_def); end
    checks++; if (busy_def !== 1'b0) begin errors++; $display("[TB] FAIL lat_same_cycle_busy got %b want 0", busy_def); end
    checks++; if (tbr_def !== 1'b0) begin errors++; $display("[TB] FAIL lat_same_cycle_tbr got %b want 0", tbr_def); end
    strobe();
    checks++; if (txd_def !== 1'b0) begin errors++; $display("[TB] FAIL lat_next_txd got %b want 0", txd_def); end
    checks++; if (busy_def !== 1'b1) begin errors++; $display("[TB] FAIL lat_next_busy got %b want 1", busy_def); end
  endtask

  task automatic test_end_write();
    logic [9:0] exp;
    exp = {1'b1, 8'h00, 1'b0};
    do_reset();
    host_write(8'h00);
    clk_cycles(1);
    for (int i = 0; i < 10; i++) begin
      strobe();
      checks++; if (txd_def !== exp[i]) begin errors++; $display("[TB] FAIL endwr_bit%0d got %b want %b", i, txd_def, exp[i]); end
      clk_cycles(15);
    end
    wen   = 1'b1;
    wdata = 8'hF0;
    baud  = 1'b1;
    @(negedge clk);
    wen   = 1'b0;
    baud  = 1'b0;
    checks++; if (txd_def !== 1'b1) begin errors++; $display("[TB] FAIL endwr_idle_txd got %b want 1", txd_def); end
    checks++; if (busy_def !== 1'b0) begin errors++; $display("[TB] FAIL endwr_idle_busy got %b want 0", busy_def); end
    checks++; if (tbr_def !== 1'b0) begin errors++; $display("[TB] FAIL endwr_captured_tbr got %b want 0", tbr_def); end
    clk_cycles(15);
    strobe();
    checks++; if (txd_def !== 1'b0) begin errors++; $display("[TB] FAIL endwr_start_txd got %b want 0", txd_def); end
    checks++; if (busy_def !== 1'b1) begin errors++; $display("[TB] FAIL endwr_start_busy got %b want 1", busy_def); end
    checks++; if (tbr_def !== 1'b1) begin errors++; $display("[TB] FAIL endwr_start_tbr got %b want 1", tbr_def); end
  endtask

  initial begin
    rst   = 1'b1;
    baud  = 1'b0;
    wen   = 1'b0;
    wdata = 8'h00;
    @(negedge clk);
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_parity();
    test_stop2();
    test_reset_mid_frame();
    test_baud_stuck();
    test_latency();
    test_end_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
